// File: rtl/serial_cmp_der_izq_ctrl_if.sv
// Operand/result handshake bundle for the serial right-to-left comparator sequencer.
interface serial_cmp_der_izq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             x0;
    logic             out_valid;
    logic             out_ready;
    logic             result;
    logic             eq;

    modport master (
        output in_valid, op_a, op_b, x0, out_ready,
        input  in_ready, out_valid, result, eq
    );

    modport slave (
        input  in_valid, op_a, op_b, x0, out_ready,
        output in_ready, out_valid, result, eq
    );
endinterface

// File: rtl/serial_cmp_der_izq_ctrl.sv
// Feeds an external comparator cell one bit pair per clock, LSB first, and
// returns the final carried state bit as the compare result (A<B or A<=B).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// RUN   | WIDTH cycles, cell driven from shift registers, x <= cell_p
// DONE  | result/eq held with out_valid until out_ready
module serial_cmp_der_izq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    serial_cmp_der_izq_ctrl_if.slave    bus,
    output logic                        cell_a,
    output logic                        cell_b,
    output logic                        cell_x,
    input  logic                        cell_p,
    output logic                        busy
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             x;
    logic             eqr;
    logic [CW-1:0]    cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             result_r;
    logic             eq_r;
    logic             busy_r;
    logic             bit_eq;

    assign bit_eq = ~(sa[0] ^ sb[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sa          <= '0;
            sb          <= '0;
            x           <= 1'b0;
            eqr         <= 1'b0;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= 1'b0;
            eq_r        <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        sa         <= bus.op_a;
                        sb         <= bus.op_b;
                        x          <= bus.x0;
                        eqr        <= 1'b1;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // cell_p is only trusted here, so nothing else can leak X into x
                    x   <= cell_p;
                    eqr <= eqr & bit_eq;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result_r    <= cell_p;
                        eq_r        <= eqr & bit_eq;
                        out_valid_r <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign cell_a = (state == ST_RUN) & sa[0];
    assign cell_b = (state == ST_RUN) & sb[0];
    assign cell_x = (state == ST_RUN) & x;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.eq        = eq_r;
    assign busy          = busy_r;
endmodule
